// File: rtl/rv_mem_pkg.sv
// Shared definitions for the instruction memory read pipeline.
package rv_mem_pkg;

    // Fill value and the word returned for every faulting fetch (addi x0,x0,0).
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    // Bit positions inside the two-bit fault field.
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    // One read-pipeline stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [1:0]  fault;
    } rd_stage_t;

    // Build an empty stage carrying the idle data word.
    function automatic rd_stage_t idle_stage(input logic [31:0] fill);
        rd_stage_t s;
        s.valid = 1'b0;
        s.data  = fill;
        s.fault = 2'b00;
        return s;
    endfunction

endpackage

// File: rtl/inst_mem_pipe_if.sv
// Fetch request / response bundle between the PC stage and the instruction memory.
interface inst_mem_pipe_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_fault;

    // Fetch stage side.
    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );

    // Memory side.
    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one
// combinational read port sampled by the pipeline in the accept cycle.
// Contents carry no reset so loaded programs survive rst.
module inst_mem_array #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = rv_mem_pkg::NOP_WORD
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

    // Program-load write; read of the same word in this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/inst_mem_pipe.sv
// Instruction memory with fixed 1- or 2-cycle read latency, program-load
// port, fetch-stage stall/flush and alignment/range fault reporting.
module inst_mem_pipe #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 32,
    parameter int          RD_LAT   = 1,
    parameter logic [31:0] NOP_WORD = rv_mem_pkg::NOP_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    inst_mem_pipe_if.slave           bus,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data
);
    import rv_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic             accept_s;
    logic             misaligned_s;
    logic             out_of_range_s;
    logic [1:0]       fault_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [31:0]      rd_data_s;
    logic             wr_en_s;
    rd_stage_t        s1_r;
    rd_stage_t        s1_next_s;
    rd_stage_t        out_s;

    // The program port wins over reads, so the array never sees a collision.
    assign bus.req_ready = !stall && !prog_we && !rst;
    assign accept_s      = bus.req_valid && bus.req_ready;
    assign wr_en_s       = prog_we && !rst;

    assign rd_idx_s       = bus.req_addr[2 +: IDX_W];
    assign misaligned_s   = (bus.req_addr[1:0] != 2'b00);
    assign out_of_range_s = ((bus.req_addr >> 2) >= ADDR_W'(DEPTH));

    // Assemble the fault field from its named bit positions.
    always_comb begin
        fault_s                 = 2'b00;
        fault_s[FAULT_MISALIGN] = misaligned_s;
        fault_s[FAULT_RANGE]    = out_of_range_s;
    end

    inst_mem_array #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .we      (wr_en_s),
        .wr_idx  (prog_addr),
        .wr_data (prog_data),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

    // First stage: capture the word read in the accept cycle; flush beats stall.
    always_comb begin
        s1_next_s = s1_r;
        if (flush) begin
            s1_next_s = idle_stage(NOP_WORD);
        end else if (stall) begin
            s1_next_s = s1_r;
        end else if (accept_s) begin
            s1_next_s.valid = 1'b1;
            s1_next_s.fault = fault_s;
            s1_next_s.data  = (fault_s != 2'b00) ? NOP_WORD : rd_data_s;
        end else begin
            s1_next_s = idle_stage(NOP_WORD);
        end
    end

    // First stage register, cleared asynchronously so reset drops in-flight reads at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= idle_stage(NOP_WORD);
        end else begin
            s1_r <= s1_next_s;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            rd_stage_t s2_r;
            rd_stage_t s2_next_s;

            // Second stage follows the first unless stalled or flushed.
            always_comb begin
                s2_next_s = s2_r;
                if (flush) begin
                    s2_next_s = idle_stage(NOP_WORD);
                end else if (stall) begin
                    s2_next_s = s2_r;
                end else begin
                    s2_next_s = s1_r;
                end
            end

            // Second stage register driving the response outputs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_r <= idle_stage(NOP_WORD);
                end else begin
                    s2_r <= s2_next_s;
                end
            end

            assign out_s = s2_r;
        end else begin : g_lat1
            assign out_s = s1_r;
        end
    endgenerate

    assign bus.rsp_valid = out_s.valid;
    assign bus.rsp_data  = out_s.data;
    assign bus.rsp_fault = out_s.fault;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance share all stimulus,
// and each is checked against hand-derived expectations for its own latency.
module tb_inst_mem_pipe;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h00a00193;
    localparam logic [31:0] W1  = 32'h00100093;
    localparam logic [31:0] W2  = 32'h00500113;
    localparam logic [31:0] W3  = 32'h11111111;
    localparam logic [31:0] WDB = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        req_valid;
    logic [31:0] req_addr;

    int n_vec  = 0;
    int n_miss = 0;

    inst_mem_pipe_if #(.ADDR_W(32)) b1 ();
    inst_mem_pipe_if #(.ADDR_W(32)) b2 ();

    assign b1.req_valid = req_valid;
    assign b1.req_addr  = req_addr;
    assign b2.req_valid = req_valid;
    assign b2.req_addr  = req_addr;

    inst_mem_pipe #(.DEPTH(256), .ADDR_W(32), .RD_LAT(1), .NOP_WORD(NOP)) u_lat1 (
        .clk(clk), .rst(rst), .bus(b1), .stall(stall), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    inst_mem_pipe #(.DEPTH(256), .ADDR_W(32), .RD_LAT(2), .NOP_WORD(NOP)) u_lat2 (
        .clk(clk), .rst(rst), .bus(b2), .stall(stall), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic prog(input logic [7:0] idx, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = idx;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    // Single isolated fetch, checked on both latencies.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_f);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk({tag, "_ready"}, 32'(b1.req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_l1_valid"}, 32'(b1.rsp_valid), 32'd1);
        chk({tag, "_l1_data"},  b1.rsp_data, exp_d);
        chk({tag, "_l1_fault"}, 32'(b1.rsp_fault), 32'(exp_f));
        chk({tag, "_l2_early"}, 32'(b2.rsp_valid), 32'd0);
        tick();
        chk({tag, "_l2_valid"}, 32'(b2.rsp_valid), 32'd1);
        chk({tag, "_l2_data"},  b2.rsp_data, exp_d);
        chk({tag, "_l2_fault"}, 32'(b2.rsp_fault), 32'(exp_f));
        chk({tag, "_l1_once"},  32'(b1.rsp_valid), 32'd0);
        tick();
        chk({tag, "_l2_once"},  32'(b2.rsp_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 8'd0;
        prog_data = 32'd0;
        req_valid = 1'b1;
        req_addr  = 32'd0;

        // Reset state.
        #3;
        chk("rst_ready", 32'(b1.req_ready), 32'd0);
        chk("rst_l1_valid", 32'(b1.rsp_valid), 32'd0);
        chk("rst_l1_data", b1.rsp_data, NOP);
        chk("rst_l2_fault", 32'(b2.rsp_fault), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Program port has priority over a pending request.
        prog_we   = 1'b1;
        prog_addr = 8'd0;
        prog_data = W0;
        #1;
        chk("wprio_ready", 32'(b1.req_ready), 32'd0);
        tick();
        prog(8'd1, W1);
        prog(8'd2, W2);
        prog(8'd3, W3);
        req_valid = 1'b0;
        tick();
        chk("wprio_no_rsp_l1", 32'(b1.rsp_valid), 32'd0);
        chk("wprio_no_rsp_l2", 32'(b2.rsp_valid), 32'd0);

        // Back-to-back reads of addr 4 and 8.
        req_valid = 1'b1;
        req_addr  = 32'd4;
        tick();
        req_addr  = 32'd8;
        chk("b2b_a_l1_v", 32'(b1.rsp_valid), 32'd1);
        chk("b2b_a_l1_d", b1.rsp_data, W1);
        chk("b2b_a_l1_f", 32'(b1.rsp_fault), 32'd0);
        chk("b2b_a_l2_v", 32'(b2.rsp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("b2b_b_l1_v", 32'(b1.rsp_valid), 32'd1);
        chk("b2b_b_l1_d", b1.rsp_data, W2);
        chk("b2b_a_l2_v2", 32'(b2.rsp_valid), 32'd1);
        chk("b2b_a_l2_d", b2.rsp_data, W1);
        tick();
        chk("b2b_end_l1_v", 32'(b1.rsp_valid), 32'd0);
        chk("b2b_b_l2_v", 32'(b2.rsp_valid), 32'd1);
        chk("b2b_b_l2_d", b2.rsp_data, W2);
        tick();
        chk("b2b_end_l2_v", 32'(b2.rsp_valid), 32'd0);

        // Faults and the last in-range word (still the fill value).
        do_read("mis6",   32'd6,    NOP, 2'b01);
        do_read("rng1024", 32'd1024, NOP, 2'b10);
        do_read("both1025", 32'd1025, NOP, 2'b11);
        do_read("last1020", 32'd1020, NOP, 2'b00);
        do_read("big", 32'h8000_0000, NOP, 2'b10);

        // Stall for three cycles right after accepting addr 0.
        req_valid = 1'b1;
        req_addr  = 32'd0;
        tick();
        stall    = 1'b1;
        req_addr = 32'd4;
        #1;
        chk("stall_ready", 32'(b1.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready_hold", 32'(b2.req_ready), 32'd0);
            chk("stall_l1_v", 32'(b1.rsp_valid), 32'd1);
            chk("stall_l1_d", b1.rsp_data, W0);
            chk("stall_l2_v", 32'(b2.rsp_valid), 32'd0);
        end
        stall     = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("stall_l2_out_v", 32'(b2.rsp_valid), 32'd1);
        chk("stall_l2_out_d", b2.rsp_data, W0);
        chk("stall_l1_done", 32'(b1.rsp_valid), 32'd0);
        tick();
        chk("stall_l2_once", 32'(b2.rsp_valid), 32'd0);

        // Flush together with the third of three consecutive accepts.
        req_valid = 1'b1;
        req_addr  = 32'd0;
        tick();
        req_addr  = 32'd4;
        tick();
        req_addr  = 32'd8;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("flush_l1_v", 32'(b1.rsp_valid), 32'd0);
            chk("flush_l2_v", 32'(b2.rsp_valid), 32'd0);
            tick();
        end
        do_read("post_flush12", 32'd12, W3, 2'b00);

        // Old-data: write idx 3 the cycle after it was accepted.
        req_valid = 1'b1;
        req_addr  = 32'd12;
        tick();
        req_valid = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 8'd3;
        prog_data = WDB;
        chk("old_l1_d", b1.rsp_data, W3);
        tick();
        prog_we = 1'b0;
        chk("old_l2_v", 32'(b2.rsp_valid), 32'd1);
        chk("old_l2_d", b2.rsp_data, W3);
        tick();
        do_read("new_idx3", 32'd12, WDB, 2'b00);

        // Asynchronous reset with a read sitting in S1.
        req_valid = 1'b1;
        req_addr  = 32'd4;
        tick();
        req_valid = 1'b0;
        chk("prerst_l1_v", 32'(b1.rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_l1_v", 32'(b1.rsp_valid), 32'd0);
        chk("arst_l1_d", b1.rsp_data, NOP);
        chk("arst_l1_f", 32'(b1.rsp_fault), 32'd0);
        chk("arst_ready", 32'(b1.req_ready), 32'd0);
        prog_we   = 1'b1;
        prog_addr = 8'd1;
        prog_data = 32'h0bad0bad;
        tick();
        chk("arst_l2_v", 32'(b2.rsp_valid), 32'd0);
        prog_we = 1'b0;
        rst     = 1'b0;
        tick();
        chk("postrst_l2_v", 32'(b2.rsp_valid), 32'd0);
        do_read("survive_w1", 32'd4, W1, 2'b00);
        do_read("survive_w0", 32'd0, W0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
